// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: the NOP used for poisoned
// IF/ID entries, fetch exception cause codes and the fetch FSM encoding.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  // True when the low two PC bits make the fetch address non word-aligned.
  function automatic logic pcMisaligned(input logic [1:0] pcLow);
    return pcLow != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Two free-running 64-bit event counters for the fetch stage: captured
// entries and stall cycles. Both wrap silently on overflow. Only built when
// FETCH_PERF_EN is defined.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchInc,
  input  logic        stallInc,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stalls
);

  logic [63:0] fetched_q, fetched_d;
  logic [63:0] stalls_q, stalls_d;

  // Next-count logic: each counter bumps by one on its own event.
  always_comb begin
    fetched_d = fetched_q;
    stalls_d  = stalls_q;
    if (fetchInc) fetched_d = fetched_q + 64'd1;
    if (stallInc) stalls_d  = stalls_q + 64'd1;
  end

  // Counter registers, cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the architectural fetch PC, drives it to the
// combinational instruction memory and captures the returned word (or a
// fetch exception) into the IF/ID slot with a valid/ready handshake.
// After a fetch exception the stage halts until a redirect arrives.
// Optional macro FETCH_PERF_EN adds perf_fetched/perf_stalls counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_addr,
  input  logic [31:0]     imem_instr,
  input  logic            imem_exc_en,
  input  logic [3:0]      imem_exc_code,
  input  logic [XLEN-1:0] imem_exc_val,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic            id_exc_en,
  output logic [3:0]      id_exc_code,
  output logic [XLEN-1:0] id_exc_val,
`ifdef FETCH_PERF_EN
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_stalls,
`endif
  output logic            fetch_halted
);

  fetch_state_e    state_q, state_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            idValid_q, idValid_d;
  logic [XLEN-1:0] idPc_q, idPc_d;
  logic [31:0]     idInstr_q, idInstr_d;
  logic            idExcEn_q, idExcEn_d;
  logic [3:0]      idExcCode_q, idExcCode_d;
  logic [XLEN-1:0] idExcVal_q, idExcVal_d;

  logic accept;
  logic misaligned;

  // The slot can take a new entry when it is empty or being drained.
  assign accept     = !idValid_q || id_ready;
  assign misaligned = pcMisaligned(pc_q[1:0]);

  // Next-state logic. Redirect beats capture, capture beats hold; a
  // redirect also kills any entry sitting in the slot, stalled or not.
  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    pc_d        = pc_q;
    idValid_d   = idValid_q;
    idPc_d      = idPc_q;
    idInstr_d   = idInstr_q;
    idExcEn_d   = idExcEn_q;
    idExcCode_d = idExcCode_q;
    idExcVal_d  = idExcVal_q;

    if (redirect_en) begin
      pc_d      = redirect_pc;
      idValid_d = 1'b0;
      state_d   = FETCH_RUN;
      halted_d  = 1'b0;
    end else if (state_q == FETCH_RUN) begin
      if (accept) begin
        idValid_d = 1'b1;
        idPc_d    = pc_q;
        if (misaligned) begin
          // Alignment is checked before the memory result is trusted.
          idInstr_d   = NOP_INSTR;
          idExcEn_d   = 1'b1;
          idExcCode_d = EXC_INSTR_MISALIGNED;
          idExcVal_d  = pc_q;
          state_d     = FETCH_HALT;
          halted_d    = 1'b1;
        end else if (imem_exc_en) begin
          idInstr_d   = NOP_INSTR;
          idExcEn_d   = 1'b1;
          idExcCode_d = imem_exc_code;
          idExcVal_d  = imem_exc_val;
          state_d     = FETCH_HALT;
          halted_d    = 1'b1;
        end else begin
          idInstr_d   = imem_instr;
          idExcEn_d   = 1'b0;
          idExcCode_d = '0;
          idExcVal_d  = '0;
          pc_d        = pc_q + XLEN'(4);
        end
      end
    end else begin
      // Halted: nothing new is fetched, the last entry drains once taken.
      if (id_ready) idValid_d = 1'b0;
    end
  end

  // Fetch FSM and IF/ID slot registers; the halted flag is registered
  // alongside the state so fetch_halted comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH_RUN;
      halted_q    <= 1'b0;
      pc_q        <= RESET_VECTOR;
      idValid_q   <= 1'b0;
      idPc_q      <= '0;
      idInstr_q   <= NOP_INSTR;
      idExcEn_q   <= 1'b0;
      idExcCode_q <= '0;
      idExcVal_q  <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      pc_q        <= pc_d;
      idValid_q   <= idValid_d;
      idPc_q      <= idPc_d;
      idInstr_q   <= idInstr_d;
      idExcEn_q   <= idExcEn_d;
      idExcCode_q <= idExcCode_d;
      idExcVal_q  <= idExcVal_d;
    end
  end

  assign pc_addr      = pc_q;
  assign id_valid     = idValid_q;
  assign id_pc        = idPc_q;
  assign id_instr     = idInstr_q;
  assign id_exc_en    = idExcEn_q;
  assign id_exc_code  = idExcCode_q;
  assign id_exc_val   = idExcVal_q;
  assign fetch_halted = halted_q;

`ifdef FETCH_PERF_EN
  logic perfFetchInc;
  logic perfStallInc;

  // Event strobes: every capture (exceptions included) and every RUN-state
  // cycle blocked by a full, unready slot.
  assign perfFetchInc = !redirect_en && (state_q == FETCH_RUN) && accept;
  assign perfStallInc = !redirect_en && (state_q == FETCH_RUN) && !accept;

  fetch_perf_ctr u_perf (
    .clk          (clk),
    .rst          (rst),
    .fetchInc     (perfFetchInc),
    .stallInc     (perfStallInc),
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls)
  );
`endif

endmodule
